// File: rtl/integral_trigger_pkg.sv
// rtl/integral_trigger_pkg.sv - Shared types and helpers for the integral window trigger
// Purpose: SUM_W derivation, controller state enum and the pipeline stage record.
// Ports: none (package).
package integral_trigger_pkg;

  // Integral width: enough headroom for WIN_LEN full-scale samples.
  function automatic int sum_width(input int data_w, input int win_len);
    return data_w + $clog2(win_len);
  endfunction

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // Stage fields are sized for the largest supported configuration
  // (CH_W <= 16, DATA_W <= 32, SUM_W <= 40, WIN_LEN <= 64); the datapath
  // slices the low bits it needs.
  localparam int PIPE_CH_W   = 16;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_PTR_W  = 8;
  localparam int PIPE_SUM_W  = 40;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_CH_W-1:0]   ch;
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_PTR_W-1:0]  ptr;
    logic [PIPE_PTR_W-1:0]  fill;
    logic [PIPE_SUM_W-1:0]  sum;
  } stage_t;

endpackage

// File: rtl/integral_window_ram.sv
// rtl/integral_window_ram.sv - Simple dual-port synchronous RAM, read-first
// Purpose: one write port, one registered read port; a read and write to the
//   same address on the same edge returns the old contents.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port (1-cycle latency).
module integral_window_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/integral_window_trigger.sv
// rtl/integral_window_trigger.sv - Multi-channel sliding-window integral trigger
// Purpose: per channel, keeps the last WIN_LEN samples and their running sum;
//   every accepted sample yields the window integral and a threshold decision.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid, in_ready             sample handshake (in_ready high in RUN)
//   in_ch, in_data                 sample channel and value
//   cfg_wr, cfg_ch, cfg_thresh     per-channel threshold write
//   cfg_hyst                       hysteresis width (hysteresis build only)
//   out_valid, out_ch, out_sum,
//   out_decision                   result, registered three edges after acceptance
//   init_done                      initialisation sweep finished
// Build option: INTEGRAL_TRIGGER_HYST_EN adds cfg_hyst and per-channel arming.
module integral_window_trigger
  import integral_trigger_pkg::*;
#(
  parameter  int DATA_W  = 12,
  parameter  int WIN_LEN = 5,
  parameter  int NUM_CH  = 128,
  parameter  int CH_W    = 7,
  localparam int SUM_W   = sum_width(DATA_W, WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [SUM_W-1:0]  cfg_thresh,
`ifdef INTEGRAL_TRIGGER_HYST_EN
  input  logic [SUM_W-1:0]  cfg_hyst,
`endif
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_decision,
  output logic              init_done
);

  localparam int              PTR_W     = $clog2(WIN_LEN);
  localparam int              FILL_W    = $clog2(WIN_LEN + 1);
  localparam logic [CH_W:0]   CH_LIMIT  = (CH_W+1)'(NUM_CH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WIN_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_LEN);

  state_t            state;
  logic [CH_W-1:0]   init_idx;
  logic              in_init, accept, cfg_accept;

  logic [PTR_W-1:0]  ptr_q  [NUM_CH];
  logic [FILL_W-1:0] fill_q [NUM_CH];
  logic [PTR_W-1:0]  cur_ptr, nxt_ptr;
  logic [FILL_W-1:0] cur_fill, nxt_fill;

  logic [DATA_W-1:0] hist_rd [WIN_LEN];
  logic [SUM_W-1:0]  sum_rd, thr_rd, s2_thr;
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  base_sum, new_sum, s2_sum;
  logic [CH_W-1:0]   s1_ch, s2_ch;
  logic              dec;
  stage_t            s1_d, s1, s2_d, s2;

  logic              s3_valid, s3_dec;
  logic [CH_W-1:0]   s3_ch;
  logic [SUM_W-1:0]  s3_sum;
  logic              pipe_unused;

`ifdef INTEGRAL_TRIGGER_HYST_EN
  logic              armed_q [NUM_CH];
  logic [SUM_W-1:0]  thr_lo;
`endif

  assign in_init    = (state == INIT);
  assign accept     = rst_n && in_valid && in_ready && ({1'b0, in_ch} < CH_LIMIT);
  assign cfg_accept = rst_n && cfg_wr && (state == RUN) && ({1'b0, cfg_ch} < CH_LIMIT);
  assign pipe_unused = ^{s1, s2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_idx  <= '0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == CH_W'(NUM_CH - 1)) begin
        state     <= RUN;
        in_ready  <= 1'b1;
        init_done <= 1'b1;
      end
    end
  end

  // Pointer and fill count are registers updated on the accept edge itself,
  // so back-to-back samples on one channel always see current values.
  always_comb begin
    cur_ptr  = ptr_q[in_ch];
    cur_fill = fill_q[in_ch];
    nxt_ptr  = (cur_ptr == PTR_LAST) ? '0 : cur_ptr + 1'b1;
    nxt_fill = (cur_fill == FILL_FULL) ? cur_fill : cur_fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (in_init) begin
      ptr_q[init_idx]  <= '0;
      fill_q[init_idx] <= '0;
    end else if (accept) begin
      ptr_q[in_ch]  <= nxt_ptr;
      fill_q[in_ch] <= nxt_fill;
    end
  end

  // One history bank per window slot lets the sweep clear a whole channel per
  // clock. The slot is overwritten on the accept edge; read-first returns the
  // sample being retired.
  for (genvar k = 0; k < WIN_LEN; k++) begin : g_hist
    integral_window_ram #(.DEPTH(NUM_CH), .WIDTH(DATA_W), .ADDR_W(CH_W)) u_hist (
      .clk   (clk),
      .we    (in_init || (accept && (cur_ptr == PTR_W'(k)))),
      .waddr (in_init ? init_idx : in_ch),
      .wdata (in_init ? '0 : in_data),
      .raddr (in_ch),
      .rdata (hist_rd[k])
    );
  end

  integral_window_ram #(.DEPTH(NUM_CH), .WIDTH(SUM_W), .ADDR_W(CH_W)) u_sum (
    .clk   (clk),
    .we    (in_init || s1.valid),
    .waddr (in_init ? init_idx : s1_ch),
    .wdata (in_init ? '0 : new_sum),
    .raddr (in_ch),
    .rdata (sum_rd)
  );

  // A sample on the same edge as a cfg write reads the old threshold.
  integral_window_ram #(.DEPTH(NUM_CH), .WIDTH(SUM_W), .ADDR_W(CH_W)) u_thr (
    .clk   (clk),
    .we    (in_init || cfg_accept),
    .waddr (in_init ? init_idx : cfg_ch),
    .wdata (in_init ? '1 : cfg_thresh),
    .raddr (in_ch),
    .rdata (thr_rd)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.valid = accept;
    s1_d.ch    = PIPE_CH_W'(in_ch);
    s1_d.data  = PIPE_DATA_W'(in_data);
    s1_d.ptr   = PIPE_PTR_W'(cur_ptr);
    s1_d.fill  = PIPE_PTR_W'(nxt_fill);
  end

  // The sum RAM read races the previous sample's write-back on the same edge,
  // so a same-channel result sitting in s2 is forwarded. Older results have
  // already landed in the RAM.
  always_comb begin
    s1_ch    = s1.ch[CH_W-1:0];
    oldest   = hist_rd[s1.ptr[PTR_W-1:0]];
    base_sum = (s2.valid && (s2.ch == s1.ch)) ? s2.sum[SUM_W-1:0] : sum_rd;
    new_sum  = base_sum - SUM_W'(oldest) + SUM_W'(s1.data[DATA_W-1:0]);
    s2_d     = s1;
    s2_d.sum = PIPE_SUM_W'(new_sum);
  end

  always_comb begin
    s2_ch  = s2.ch[CH_W-1:0];
    s2_sum = s2.sum[SUM_W-1:0];
    dec    = (s2.fill[FILL_W-1:0] == FILL_FULL) && (s2_sum > s2_thr);
`ifdef INTEGRAL_TRIGGER_HYST_EN
    thr_lo = (s2_thr > cfg_hyst) ? (s2_thr - cfg_hyst) : '0;
    if (armed_q[s2_ch]) dec = (s2_sum > thr_lo);
`endif
  end

`ifdef INTEGRAL_TRIGGER_HYST_EN
  // Armed state follows the reported decision: arm on trigger, stay armed
  // while above the lowered level, disarm once it drops out.
  always_ff @(posedge clk) begin
    if (in_init)       armed_q[init_idx] <= 1'b0;
    else if (s2.valid) armed_q[s2_ch]    <= dec;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1           <= '0;
      s2           <= '0;
      s2_thr       <= '0;
      s3_valid     <= 1'b0;
      s3_ch        <= '0;
      s3_sum       <= '0;
      s3_dec       <= 1'b0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_sum      <= '0;
      out_decision <= 1'b0;
    end else begin
      s1           <= s1_d;
      s2           <= s2_d;
      s2_thr       <= thr_rd;
      s3_valid     <= s2.valid;
      s3_ch        <= s2_ch;
      s3_sum       <= s2_sum;
      s3_dec       <= s2.valid && dec;
      out_valid    <= s3_valid;
      out_ch       <= s3_ch;
      out_sum      <= s3_sum;
      out_decision <= s3_dec;
    end
  end

endmodule

// File: tb/tb_integral_window_trigger.sv
// tb/tb_integral_window_trigger.sv - Scoreboard bench for integral_window_trigger
module tb_integral_window_trigger;

  localparam int DATA_W  = 12;
  localparam int WIN_LEN = 5;
  localparam int NUM_CH  = 128;
  localparam int CH_W    = 7;
  localparam int SUM_W   = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [SUM_W-1:0]  cfg_thresh = '0;
`ifdef INTEGRAL_TRIGGER_HYST_EN
  logic [SUM_W-1:0]  cfg_hyst = '0;
`endif
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [SUM_W-1:0]  out_sum;
  logic              out_decision;
  logic              init_done;

  always #5 clk = ~clk;

  integral_window_trigger #(
    .DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ch        (in_ch),
    .in_data      (in_data),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_thresh   (cfg_thresh),
`ifdef INTEGRAL_TRIGGER_HYST_EN
    .cfg_hyst     (cfg_hyst),
`endif
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_sum      (out_sum),
    .out_decision (out_decision),
    .init_done    (init_done)
  );

  typedef struct {
    int ch;
    int sum;
    int dec;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got ch=%0d sum=%0d dec=%0d, required no output",
                 out_ch, out_sum, out_decision);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_ch) != e.ch || int'(out_sum) != e.sum ||
            int'(out_decision) != e.dec || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: got ch=%0d sum=%0d dec=%0d cyc=%0d, required ch=%0d sum=%0d dec=%0d cyc=%0d",
                   out_ch, out_sum, out_decision, cyc, e.ch, e.sum, e.dec, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Called on a negedge; the sample is accepted at the next posedge and its
  // result must be visible at the negedge four posedges from now.
  task automatic sample(input int ch, input int data, input int es, input int ed);
    exp_t e;
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = DATA_W'(data);
    e.ch = ch; e.sum = es; e.dec = ed; e.cyc = cyc + 4;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_wr   = 1'b0;
  endtask

  task automatic cfg(input int ch, input int thr);
    cfg_wr     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_thresh = SUM_W'(thr);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < NUM_CH + 20; i++) begin
      @(negedge clk);
      if (init_done) break;
    end
    in_valid = 1'b0;
    check("init_done_after_reset", int'(init_done), 1);
  endtask

  // Optionally keeps a ch 7 sample on the bus through INIT; it must be ignored.
  task automatic do_reset(input logic drive_in);
    rst_n    = 1'b0;
    in_valid = drive_in;
    in_ch    = CH_W'(7);
    in_data  = DATA_W'(55);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
  endtask

  function automatic int ramp_sum(input int i);
    int s = 0;
    for (int j = (i >= WIN_LEN - 1) ? i - (WIN_LEN - 1) : 0; j <= i; j++) s += j;
    return s;
  endfunction

  function automatic int const_sum(input int n, input int v);
    return ((n + 1 < WIN_LEN) ? n + 1 : WIN_LEN) * v;
  endfunction

  initial begin : stim
    exp_t d;
    int   early_bad = 0;
    int   n8;

    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_init_done", int'(init_done), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_ch", int'(out_ch), 0);
    check("reset_out_sum", int'(out_sum), 0);
    check("reset_out_decision", int'(out_decision), 0);

    rst_n = 1'b1;
    for (int i = 1; i <= NUM_CH; i++) begin
      @(posedge clk);
      #1;
      if (i < NUM_CH && (in_ready || init_done || out_valid)) early_bad++;
    end
    check("init_quiet_during_sweep", early_bad, 0);
    check("init_done_at_num_ch", int'(init_done), 1);
    check("in_ready_at_num_ch", int'(in_ready), 1);
    @(negedge clk);

    // Threshold 50: 50 is not above 50, 51 is.
    cfg(3, 50);
    sample(3, 10, 10, 0);
    sample(3, 10, 20, 0);
    sample(3, 10, 30, 0);
    sample(3, 10, 40, 0);
    sample(3, 10, 50, 0);
    sample(3, 11, 51, 1);
    drain();

    // Full-scale window, then retire one full-scale sample.
    sample(0, 4095, 4095, 0);
    sample(0, 4095, 8190, 0);
    sample(0, 4095, 12285, 0);
    sample(0, 4095, 16380, 0);
    sample(0, 4095, 20475, 0);
    sample(0, 0, 16380, 0);
    drain();

    // Threshold write in the same cycle as a sample uses the old threshold.
    cfg(2, 100);
    for (int i = 0; i < 5; i++) sample(2, 8, 8 * (i + 1), 0);
    cfg_wr = 1'b1; cfg_ch = CH_W'(2); cfg_thresh = SUM_W'(5);
    sample(2, 8, 40, 0);
    sample(2, 8, 40, 1);
    drain();

    // Same channel every cycle.
    for (int i = 0; i < 20; i++) sample(7, i, ramp_sum(i), 0);
    drain();

    // Gap of 1 on ch 7.
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      sample(7, k, ramp_sum(k), 0);
      sample(8, 100, const_sum(k, 100), 0);
    end
    drain();

    // Gap of 2 on ch 7; ch 8 alternates gap 0 and gap 1.
    do_reset(1'b0);
    n8 = 0;
    for (int k = 0; k < 10; k++) begin
      sample(7, k, ramp_sum(k), 0);
      sample(8, 100, const_sum(n8, 100), 0);
      n8++;
      sample(8, 100, const_sum(n8, 100), 0);
      n8++;
    end
    drain();

    // Reset while ch 1 results are in flight: only the first one emerges.
    sample(1, 10, 10, 0);
    sample(1, 20, 30, 0);
    sample(1, 30, 60, 0);
    sample(1, 40, 100, 0);
    rst_n = 1'b0;
    check("inflight_before_reset", int'(exp_q.size() >= 3), 1);
    repeat (3) if (exp_q.size() > 0) d = exp_q.pop_back();
    @(posedge clk);
    #1;
    check("out_valid_after_reset", int'(out_valid), 0);
    check("in_ready_after_reset", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    sample(1, 77, 77, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/integral_window_trigger.md
Name: integral_window_trigger

Overview:
- Parametrised multi-channel sliding-window integral trigger for the digitiser front end.
- Keeps, per channel, a circular history of the last WIN_LEN samples and a running sum.
- Each accepted sample produces a full-width integral and a threshold decision for its channel.
- Per-channel thresholds are runtime-programmable; sits between the ADC sample mux and the thresholder FSM.

Parameters:
- DATA_W, 12, sample width (unsigned).
- WIN_LEN, 5, window length in samples, 2..64.
- NUM_CH, 128, channel count.
- CH_W, 7, channel index width, >= clog2(NUM_CH).
- SUM_W, DATA_W+clog2(WIN_LEN), integral/threshold width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample strobe.
- in_ready  out  1  high when samples are accepted.
- in_ch  in  CH_W  sample channel.
- in_data  in  DATA_W  sample value.
- cfg_wr  in  1  threshold write strobe.
- cfg_ch  in  CH_W  threshold channel.
- cfg_thresh  in  SUM_W  threshold value.
- out_valid  out  1  result strobe.
- out_ch  out  CH_W  result channel.
- out_sum  out  SUM_W  window integral, including the new sample.
- out_decision  out  1  trigger decision.
- init_done  out  1  high once the initialisation sweep has finished.

Behaviour:
- Reset: in_ready=0, init_done=0, out_valid=0, out_ch=0, out_sum=0, out_decision=0.
- States are INIT and RUN.
- INIT: entered on reset, including reset mid-operation.
  - Sweeps one channel per clock for NUM_CH clocks.
  - Per channel it clears the sum, write pointer, fill count and history entries, and sets threshold to all-ones.
  - Then moves to RUN; init_done and in_ready go high in the first RUN cycle.
- RUN: a sample is accepted when in_valid && in_ready. in_ready stays 1 in RUN, so there is no backpressure.
- Per accepted sample:
  - oldest = hist[ch][ptr].
  - sum' = sum - oldest + in_data (exact, never saturates).
  - hist[ch][ptr] = in_data.
  - ptr advances; wraps WIN_LEN-1 to 0.
  - fill count increments, saturating at WIN_LEN.
- Latency: a sample accepted at edge T gives out_valid=1 for exactly one cycle after edge T+3, with out_ch, out_sum=sum' and the decision.
  - Fully pipelined, one sample per clock.
  - Result order equals acceptance order.
- Decision = (fill count after update == WIN_LEN) && (sum' > threshold[ch]).
  - Comparison is strict and unsigned.
  - Channels not yet filled never trigger.
- Hazards: results must equal a sequential reference model for any channel sequence. This includes the same channel on every cycle and the same channel with a gap of 1 or 2 cycles. Forwarding of sum, pointer and fill count is mandatory; stalling is not allowed.
- cfg_wr:
  - Accepted in RUN only; ignored in INIT.
  - Takes effect for samples accepted in later cycles.
  - A sample accepted in the same cycle on the same channel uses the old threshold.
- in_ch or cfg_ch >= NUM_CH: the operation is dropped. No output and no state change.
- in_valid during INIT: ignored.
- Memories: history of depth NUM_CH*WIN_LEN, sum and threshold of depth NUM_CH, all synchronous-read RAMs. Pointer and fill count live in registers or RAM.

Optional Feature:
- Macro: INTEGRAL_TRIGGER_HYST_EN.
- Enabled:
  - Adds input port cfg_hyst [SUM_W] and a per-channel armed bit, cleared in INIT.
  - An armed channel reports decision=1 while sum' > threshold - cfg_hyst, then disarms.
  - An unarmed channel arms when the normal decision rule is met.
  - threshold - cfg_hyst clamps at 0.
- Disabled: the stateless decision rule above applies and the port does not exist.

Decomposition:
- Package integral_trigger_pkg holds:
  - the SUM_W derivation function (clog2);
  - the state enum {INIT, RUN};
  - the pipeline stage struct (valid, ch, data, ptr, fill, sum).
- One sub-module: integral_window_ram, a generic simple dual-port synchronous RAM (DEPTH, WIDTH). It is instantiated for history, sum and threshold.

Test Plan:
- Reset then idle: init_done rises exactly NUM_CH cycles after reset release. No out_valid, in_ready=0 throughout INIT.
- Ch 3, threshold 50, samples 10,10,10,10,10,11:
  - sums 10,20,30,40,50,51;
  - decisions 0,0,0,0,0,1.
  - Fifth result is not a trigger because 50 is not > 50.
- Ch 7 every cycle for 20 samples of ramp 0..19, WIN_LEN=5: out_sum equals the sum of the last 5 samples each cycle, proving forwarding. Repeat with ch 7 at gaps of 1 and 2 cycles interleaved with ch 8.
- Saturation: 5 samples of 4095 then one 0 on ch 0 → out_sum 20475 (no overflow), then 16380.
- cfg_wr ch 2 thresh 5 in the same cycle as a ch 2 sample after fill, old threshold 100, sum 40 → decision 0. The next sample with sum 40 → decision 1.
- Mid-stream reset: assert rst_n=0 for 1 cycle while ch 1 results are in flight → out_valid drops next cycle and INIT reruns. After init_done, the first ch 1 sample gives out_sum = that sample and decision 0.
